event_logger: RTL and testbench

Downstream consumer of the spike-processing unit's `spike_detection` and `event_out` signals. Each non-zero classified event is captured as a 24-bit record:

- 2-bit class
- 6-bit count of spikes since the previous event
- 16-bit timestamp

Records are buffered in a small FIFO and drained as a 3-byte stream over a valid/ready byte interface, toward the chip's output pins or serial port.

---
 rtl/event_logger_pkg.sv | 33 +++
 rtl/event_fifo.sv | 82 ++++++++
 rtl/event_logger.sv | 142 ++++++++++++++
 tb/tb_event_logger.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_logger_pkg.sv
// Shared definitions for the event logger: record field widths, the
// "no event" classifier code, the serializer state type and the helper that
// picks one byte out of a 24-bit record.
package event_logger_pkg;

    localparam int ts_w   = 16;
    localparam int scnt_w = 6;
    localparam int rec_w  = 24;

    localparam logic [1:0]        event_none = 2'b00;
    localparam logic [scnt_w-1:0] scnt_max   = 6'd63;

    // Which byte of the head record is currently presented on the output.
    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2
    } ser_state_t;

    // Record layout is {class, spikes, ts}; byte 0 is the most significant.
    function automatic logic [7:0] select_byte(input logic [rec_w-1:0] rec,
                                               input ser_state_t       sel);
        logic [7:0] b;
        case (sel)
            BYTE0:   b = rec[23:16];
            BYTE1:   b = rec[15:8];
            BYTE2:   b = rec[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous record FIFO for the event logger.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push, pop     write request / read request (pop ignored while empty)
//   wr_data       record to store
//   rd_data       head record (valid while !empty)
//   level         number of stored records, 0..DEPTH
//   full, empty   status flags
// A push while full is still accepted when a pop happens in the same cycle.
module event_fifo
    import event_logger_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [rec_w-1:0] wr_data,
    output logic [rec_w-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [rec_w-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty   = (level_r == {LW{1'b0}});
    assign full    = (level_r == LW'(DEPTH));
    assign rd_en_s = pop && !empty;
    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign wr_en_s = push && (!full || rd_en_s);
    assign rd_data = mem_r[rd_ptr_r];
    assign level   = level_r;

    // Record storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {rec_w{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= {LW{1'b0}};
        end else begin
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + LW'(1'b1);
                2'b01:   level_r <= level_r - LW'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/event_logger.sv
// Event logger: stamps each classified event with a spike count and a
// timestamp, buffers the 24-bit records and streams them out as 3 bytes.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   spike_in      spike strobe, counted once per high cycle
//   event_in      classifier output, 2'b00 means no event
//   out_ready     sink accepts out_data this cycle
//   out_valid     a byte of the head record is presented
//   out_data      current byte of the head record
//   fifo_level    records stored, 0..DEPTH
//   overflow      sticky, an event was dropped because the FIFO was full
module event_logger
    import event_logger_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spike_in,
    input  logic [1:0]               event_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    logic [ts_w-1:0]   ts_r;
    logic [scnt_w-1:0] scnt_r;
    logic              overflow_r;
    ser_state_t        state_r;
    ser_state_t        state_next_s;

    logic              event_s;
    logic              xfer_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic [scnt_w-1:0] spikes_s;
    logic [rec_w-1:0]  rec_s;
    logic [rec_w-1:0]  head_rec_s;

    assign event_s   = (event_in != event_none);
    assign xfer_s    = !empty_s && out_ready;
    assign pop_s     = xfer_s && (state_r == BYTE2);
    assign rec_s     = {event_in, spikes_s, ts_r};
    assign out_valid = !empty_s;
    assign overflow  = overflow_r;

    // Spike count for the record includes a spike arriving in the event cycle.
    always_comb begin
        spikes_s = scnt_r;
        if (scnt_r == scnt_max) begin
            spikes_s = scnt_max;
        end else begin
            spikes_s = scnt_r + {{(scnt_w-1){1'b0}}, spike_in};
        end
    end

    // Free-running timestamp.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_r <= 16'd0;
        end else begin
            ts_r <= ts_r + 16'd1;
        end
    end

    // Saturating spike counter, cleared on every event even if it is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt_r <= {scnt_w{1'b0}};
        end else if (event_s) begin
            scnt_r <= {scnt_w{1'b0}};
        end else if (spike_in && (scnt_r != scnt_max)) begin
            scnt_r <= scnt_r + {{(scnt_w-1){1'b0}}, 1'b1};
        end
    end

    // Sticky drop flag: full and no pop making room this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (event_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end
    end

    // Serializer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= BYTE0;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Serializer next state: advance only on a transfer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BYTE0: begin
                if (xfer_s) state_next_s = BYTE1;
                else        state_next_s = BYTE0;
            end
            BYTE1: begin
                if (xfer_s) state_next_s = BYTE2;
                else        state_next_s = BYTE1;
            end
            BYTE2: begin
                if (xfer_s) state_next_s = BYTE0;
                else        state_next_s = BYTE2;
            end
            default: state_next_s = BYTE0;
        endcase
    end

    // Output byte of the head record; zero while nothing is buffered.
    always_comb begin
        out_data = 8'h00;
        if (empty_s) begin
            out_data = 8'h00;
        end else begin
            out_data = select_byte(head_rec_s, state_r);
        end
    end

    event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (event_s),
        .pop     (pop_s),
        .wr_data (rec_s),
        .rd_data (head_rec_s),
        .level   (fifo_level),
        .full    (full_s),
        .empty   (empty_s)
    );

endmodule

// File: tb/tb_event_logger.sv
// Testbench for event_logger: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a record-level reference model.
module tb_event_logger;

    localparam int DEPTH = 8;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       spike_in  = 1'b0;
    logic [1:0] event_in  = 2'b00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] fifo_level;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state: bytes still owed by the DUT, timestamp,
    // spike count, sticky overflow.
    logic [7:0] sb_q [$];
    logic [7:0] got_q [$];
    int         pend     = 0;
    int         m_ts     = 0;
    int         m_scnt   = 0;
    logic       m_ovf    = 1'b0;
    logic       in_reset = 1'b1;
    int         t4_ts    = 0;

    event_logger #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .event_in   (event_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    // One clock cycle of stimulus; the model decides acceptance from the
    // number of bytes still owed (head pops when one byte remains).
    task automatic step(input logic sp, input logic [1:0] ev, input logic rdy);
        logic        xfer;
        logic        popn;
        logic        acc;
        int          cnt;
        logic [5:0]  sp6;
        logic [15:0] ts16;
        logic [23:0] rec;
        spike_in  = sp;
        event_in  = ev;
        out_ready = rdy;
        xfer = (pend > 0) && rdy;
        popn = xfer && (pend % 3 == 1);
        acc  = 1'b0;
        rec  = 24'h000000;
        cnt  = m_scnt + int'(sp);
        if (cnt > 63) cnt = 63;
        if (ev != 2'b00) begin
            sp6  = cnt[5:0];
            ts16 = m_ts[15:0];
            rec  = {ev, sp6, ts16};
            acc  = (((pend + 2) / 3) < DEPTH) || popn;
        end
        @(posedge clk);
        if (xfer) pend--;
        if (ev != 2'b00) begin
            m_scnt = 0;
            if (acc) begin
                pend += 3;
                sb_q.push_back(rec[23:16]);
                sb_q.push_back(rec[15:8]);
                sb_q.push_back(rec[7:0]);
            end else begin
                m_ovf = 1'b1;
            end
        end else begin
            m_scnt = cnt;
        end
        m_ts = (m_ts + 1) % 65536;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && pend > 0; i++) step(1'b0, 2'b00, 1'b1);
        chk("drain_empty", int'(out_valid), 0);
    endtask

    // Asynchronous reset asserted between clock edges; model restarts.
    task automatic do_reset();
        #1;
        rst       = 1'b0;
        in_reset  = 1'b1;
        spike_in  = 1'b0;
        event_in  = 2'b00;
        out_ready = 1'b0;
        sb_q.delete();
        pend   = 0;
        m_ovf  = 1'b0;
        m_ts   = 0;
        m_scnt = 0;
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor: samples just before each rising edge and scores transfers.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (in_reset) begin
                chk("rst_valid", int'(out_valid), 0);
                chk("rst_data", int'(out_data), 0);
                chk("rst_level", int'(fifo_level), 0);
                chk("rst_overflow", int'(overflow), 0);
            end else begin
                chk("valid", int'(out_valid), int'(pend > 0));
                chk("level", int'(fifo_level), (pend + 2) / 3);
                chk("overflow", int'(overflow), int'(m_ovf));
                if (out_valid && out_ready) begin
                    got_q.push_back(out_data);
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got=0x%0h expected=none", out_data);
                    end else begin
                        chk("byte", int'(out_data), int'(sb_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rp;
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b0;

        // Single event in cycle 20 after 5 spikes.
        got_q.delete();
        repeat (5)  step(1'b1, 2'b00, 1'b1);
        repeat (15) step(1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b10, 1'b1);
        drain();
        chk("t1_size", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("t1_b0", int'(got_q[0]), 'h85);
            chk("t1_b1", int'(got_q[1]), 'h00);
            chk("t1_b2", int'(got_q[2]), 'h14);
        end

        // Spike counter saturation, then a spike-free event.
        got_q.delete();
        repeat (70) step(1'b1, 2'b00, 1'b1);
        step(1'b0, 2'b01, 1'b1);
        step(1'b0, 2'b01, 1'b1);
        drain();
        chk("t2_size", got_q.size(), 6);
        if (got_q.size() == 6) begin
            chk("t2_sat", int'(got_q[0]), 'h7F);
            chk("t2_clr", int'(got_q[3]), 'h40);
        end

        // Backpressure: 10 events into an 8-deep FIFO.
        got_q.delete();
        for (int i = 0; i < 10; i++) step(1'($urandom % 2), 2'($urandom_range(1, 3)), 1'b0);
        chk("t3_level", int'(fifo_level), 8);
        chk("t3_overflow", int'(overflow), 1);
        drain();
        chk("t3_bytes", got_q.size(), 24);
        chk("t3_overflow_sticky", int'(overflow), 1);

        // Reset after the BYTE1 transfer of a record.
        step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b1);
        do_reset();
        got_q.delete();
        repeat (3) step(1'b0, 2'b00, 1'b1);
        step(1'b1, 2'b10, 1'b1);
        drain();
        chk("t6_size", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("t6_b0", int'(got_q[0]), 'h81);
            chk("t6_b1", int'(got_q[1]), 'h00);
            chk("t6_b2", int'(got_q[2]), 'h03);
        end

        // Full FIFO: push in the same cycle as the BYTE2 transfer.
        got_q.delete();
        for (int i = 0; i < 8; i++) step(1'b0, 2'($urandom_range(1, 3)), 1'b0);
        chk("t4_full", int'(fifo_level), 8);
        step(1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b1);
        t4_ts = m_ts;
        step(1'b0, 2'b11, 1'b1);
        chk("t4_level", int'(fifo_level), 8);
        chk("t4_overflow", int'(overflow), 0);
        drain();
        chk("t4_size", got_q.size(), 27);
        if (got_q.size() == 27) begin
            chk("t4_last_b0", int'(got_q[24]), 'hC0);
            chk("t4_last_b1", int'(got_q[25]), (t4_ts >> 8) & 255);
            chk("t4_last_b2", int'(got_q[26]), t4_ts & 255);
        end

        // Randomized traffic with varying sink readiness.
        for (int c = 0; c < 6; c++) begin
            rp = $urandom_range(0, 4);
            for (int i = 0; i < 300; i++) begin
                step(1'($urandom % 2),
                     ($urandom % 3 == 0) ? 2'($urandom % 4) : 2'b00,
                     1'($urandom_range(0, 3) < rp));
            end
        end
        drain();
        chk("rand_sb_empty", sb_q.size(), 0);

        // Timestamp wrap.
        for (int i = 0; i < 70000 && m_ts != 65535; i++) step(1'b0, 2'b00, 1'b1);
        got_q.delete();
        step(1'b0, 2'b01, 1'b1);
        step(1'b0, 2'b10, 1'b1);
        drain();
        chk("t5_size", got_q.size(), 6);
        if (got_q.size() == 6) begin
            chk("t5_b1_hi", int'(got_q[1]), 'hFF);
            chk("t5_b1_lo", int'(got_q[2]), 'hFF);
            chk("t5_b2_hi", int'(got_q[4]), 'h00);
            chk("t5_b2_lo", int'(got_q[5]), 'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
